// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up when the result is loaded.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_ma;
  logic [XLEN-1:0]     r_mb;
  logic [2*XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg;
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_sign_a;
  logic                w_sign_b;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_neg_in;
  logic                w_div0;
  logic                w_ovf;
  logic [XLEN-1:0]     w_fast_res;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_prod_nxt;
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN:0]       w_rem_sh;
  logic [XLEN:0]       w_diff;
  logic                w_qbit;
  logic [XLEN-1:0]     w_rem_nxt;
  logic [XLEN-1:0]     w_quo_nxt;
  logic [XLEN-1:0]     w_rem_fix;
  logic [XLEN-1:0]     w_quo_fix;
  logic [XLEN-1:0]     w_final;
  logic                w_last;

  assign busy   = (r_state == CALC);
  assign done   = (r_state == DONE);
  assign result = r_result;

  always_comb begin
    w_accept   = start && (r_state != CALC);
    w_sign_a   = a[XLEN-1] && (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    w_sign_b   = b[XLEN-1] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
    w_abs_a    = w_sign_a ? -a : a;
    w_abs_b    = w_sign_b ? -b : b;
    w_neg_in   = (op == 3'b110) ? w_sign_a : (w_sign_a ^ w_sign_b);
    w_div0     = op[2] && (b == '0);
    w_ovf      = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // Divide-by-zero takes precedence; overflow only reachable with b = -1.
    if (w_div0)
      w_fast_res = op[1] ? a : '1;
    else
      w_fast_res = op[1] ? '0 : a;
  end

  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_mb[0] ? r_ma : {XLEN{1'b0}})};
    w_prod_nxt = {w_sum, r_acc[XLEN-1:1]};
    w_prod_fix = r_neg ? -w_prod_nxt : w_prod_nxt;
    // Divide keeps the partial remainder in the upper accumulator half and
    // shifts quotient bits into r_ma as the dividend bits shift out.
    w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_ma[XLEN-1]};
    w_diff     = w_rem_sh - {1'b0, r_mb};
    w_qbit     = !w_diff[XLEN];
    w_rem_nxt  = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    w_quo_nxt  = {r_ma[XLEN-2:0], w_qbit};
    w_rem_fix  = r_neg ? -w_rem_nxt : w_rem_nxt;
    w_quo_fix  = r_neg ? -w_quo_nxt : w_quo_nxt;
    if (r_op[2])
      w_final = r_op[1] ? w_rem_fix : w_quo_fix;
    else if (r_op[1:0] == 2'b00)
      w_final = w_prod_fix[XLEN-1:0];
    else
      w_final = w_prod_fix[2*XLEN-1:XLEN];
    w_last     = (r_cnt == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[2]) begin
            r_acc <= {w_rem_nxt, r_acc[XLEN-1:0]};
            r_ma  <= w_quo_nxt;
          end else begin
            r_acc <= w_prod_nxt;
            r_mb  <= r_mb >> 1;
          end
          if (w_last) begin
            r_state  <= DONE;
            r_result <= w_final;
          end
        end
        default: begin
          if (w_accept) begin
            r_op  <= op;
            r_ma  <= w_abs_a;
            r_mb  <= w_abs_b;
            r_neg <= w_neg_in;
            r_acc <= '0;
            r_cnt <= '0;
            if (w_div0 || w_ovf) begin
              r_state  <= DONE;
              r_result <= w_fast_res;
            end else begin
              r_state <= CALC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, compared at done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] sb_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    case (o)
      3'b000: begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
      3'b001: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return sp[63:32]; end
      3'b010: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return sp[63:32]; end
      3'b011: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return sx / sy;
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 0;
    return 32;
  endfunction

  // Drive one start cycle, push the model result, then scramble inputs.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Wait (bounded) for done; lat = posedges after the accepting edge.
  task automatic wait_done(output int lat, output int bcnt, output logic [31:0] res);
    lat = 0; bcnt = 0;
    forever begin
      if (done === 1'b1) break;
      if (busy === 1'b1) bcnt++;
      if (lat >= 200) break;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int lat, bc; logic [31:0] res, e;
    issue(3'b000, 32'd7, 32'd6);
    wait_done(lat, bc, res);
    e = sb_q.pop_front();
    n_checks++; if (res !== e) $display("FAIL mul_result: got %h expected %h", res, e); else n_pass++;
    n_checks++; if (lat !== 32) $display("FAIL mul_latency: got %0d expected 32", lat); else n_pass++;
    n_checks++; if (bc !== 32) $display("FAIL mul_busy_cycles: got %0d expected 32", bc); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL mul_done_width: got %b expected 0", done); else n_pass++;
    n_checks++; if (result !== e) $display("FAIL mul_result_hold: got %h expected %h", result, e); else n_pass++;
  endtask

  task automatic test_table(input string name, input logic [2:0] ops[4],
                            input logic [31:0] xs[4], input logic [31:0] ys[4],
                            input logic [31:0] ev[4], input int el);
    int lat, bc; logic [31:0] res, e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], xs[i], ys[i]);
      wait_done(lat, bc, res);
      e = sb_q.pop_front();
      n_checks++; if (e !== ev[i]) $display("FAIL %s_model_%0d: got %h expected %h", name, i, e, ev[i]); else n_pass++;
      n_checks++; if (res !== ev[i]) $display("FAIL %s_result_%0d: got %h expected %h", name, i, res, ev[i]); else n_pass++;
      n_checks++; if (lat !== el) $display("FAIL %s_latency_%0d: got %0d expected %0d", name, i, lat, el); else n_pass++;
    end
  endtask

  task automatic test_mulh_family;
    test_table("mulh", '{3'b001, 3'b011, 3'b010, 3'b000},
               '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
               '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
               '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001}, 32);
  endtask

  task automatic test_div;
    test_table("div", '{3'b100, 3'b110, 3'b101, 3'b111},
               '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
               '{32'd2, 32'd2, 32'd7, 32'd7},
               '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2}, 32);
  endtask

  task automatic test_special;
    test_table("special", '{3'b100, 3'b110, 3'b100, 3'b110},
               '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
               '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
               '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0}, 0);
  endtask

  task automatic test_random;
    int lat, bc, el; logic [31:0] res, e, x, y; logic [2:0] o;
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      case (i % 4)
        0: y = 32'h0;
        1: y = 32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      el = exp_lat(o, x, y);
      issue(o, x, y);
      wait_done(lat, bc, res);
      e = sb_q.pop_front();
      n_checks++; if (res !== e) $display("FAIL rand_result_%0d op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, res, e); else n_pass++;
      n_checks++; if (lat !== el) $display("FAIL rand_latency_%0d: got %0d expected %0d", i, lat, el); else n_pass++;
    end
  endtask

  task automatic test_ignore_start;
    int lat, bc, hits; logic [31:0] res, e;
    issue(3'b000, 32'd7, 32'd6);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc, res);
    e = sb_q.pop_front();
    n_checks++; if (res !== e) $display("FAIL ignore_result: got %h expected %h", res, e); else n_pass++;
    n_checks++; if (lat + 6 !== 32) $display("FAIL ignore_latency: got %0d expected 32", lat + 6); else n_pass++;
    hits = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) hits++; end
    n_checks++; if (hits !== 0) $display("FAIL ignore_no_second_op: got %0d active cycles expected 0", hits); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, bc; logic [31:0] res, e;
    issue(3'b000, 32'd3, 32'd5);
    wait_done(lat, bc, res);
    e = sb_q.pop_front();
    n_checks++; if (res !== e) $display("FAIL b2b_first_result: got %h expected %h", res, e); else n_pass++;
    start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
    sb_q.push_back(model(3'b101, 32'd100, 32'd7));
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_no_bubble: got busy=%b expected 1", busy); else n_pass++;
    wait_done(lat, bc, res);
    e = sb_q.pop_front();
    n_checks++; if (res !== e) $display("FAIL b2b_second_result: got %h expected %h", res, e); else n_pass++;
    n_checks++; if (lat !== 32) $display("FAIL b2b_second_latency: got %0d expected 32", lat); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat, bc, hits; logic [31:0] res, e;
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'hFFFF_0000; b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (result !== 32'h0) $display("FAIL rstmid_result: got %h expected 0", result); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) hits++; end
    n_checks++; if (hits !== 0) $display("FAIL rstmid_no_done: got %0d done cycles expected 0", hits); else n_pass++;
    issue(3'b011, 32'h8000_0000, 32'd2);
    wait_done(lat, bc, res);
    e = sb_q.pop_front();
    n_checks++; if (res !== 32'h1) $display("FAIL rstmid_mulhu: got %h expected 00000001", res); else n_pass++;
    n_checks++; if (res !== e) $display("FAIL rstmid_mulhu_model: got %h expected %h", res, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh_family();
    test_div();
    test_special();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
